oc_led_ctrl: RTL and testbench
==============================

OC_LED_CTRL -- requirements
Module: oc_led_ctrl

Interface
REQ-001 SHALL have parameter LedCount, default 3, number of LED channels (1..32).
REQ-002 SHALL have parameter PwmBits, default 8, brightness resolution (2..12).
REQ-003 SHALL have parameter PwmDiv, default 16, clocks per PWM count step (>=1).
REQ-004 SHALL have parameter BlinkCycles, default 39062500, clocks per blink half-period (>=2).
REQ-005 SHALL use one clock; reset is asynchronous and active-low: port clock, input, 1, sole clock.
REQ-006 SHALL have port resetN, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port cfgValid, input, 1, config write request.
REQ-008 SHALL have port cfgReady, output, 1, config write accepted when high with cfgValid.
REQ-009 SHALL have port cfgIndex, input, max(1,$clog2(LedCount)), target channel.
REQ-010 SHALL have port cfgMode, input, 2, 0=off 1=on 2=blink 3=heartbeat.
REQ-011 SHALL have port cfgBright, input, PwmBits, duty value.
REQ-012 SHALL have port debugEnable, input, 1, override all channels.
REQ-013 SHALL have port debugLed, input, LedCount, override values.
REQ-014 SHALL have port ledOut, output, LedCount, registered LED drive, active-high.
REQ-015 SHALL have port frameStart, output, 1, one-cycle pulse at each PWM frame start.

Function
REQ-016 SHALL accept a config write on any cycle where cfgValid && cfgReady; cfgReady is high at every cycle after the first clock edge following reset release.
REQ-017 SHALL write accepted cfgMode/cfgBright to the channel's pending registers on the accept edge; cfgIndex >= LedCount is accepted and discarded.
REQ-018 SHALL copy all pending registers to active registers on the cycle frameStart is high, so new settings never change mid-frame; repeated writes within one frame: last wins.
REQ-019 SHALL advance a prescaler 0..PwmDiv-1, wrapping; pwmCount (PwmBits wide) increments on prescaler wrap and wraps 2^PwmBits-1 -> 0.
REQ-020 SHALL pulse frameStart for one clock when pwmCount wraps to 0 (prescaler wrap with pwmCount all-ones).
REQ-021 SHALL compute pwmOn = (pwmCount < activeBright) OR (activeBright all-ones); activeBright 0 is always dark.
REQ-022 SHALL run a blink counter 0..BlinkCycles-1; on wrap toggle blinkPhase and increment a 3-bit heartStep (wraps 7 -> 0).
REQ-023 SHALL derive pattern: off=0, on=1, blink=blinkPhase, heartbeat=(heartStep==0 || heartStep==2).
REQ-024 SHALL drive ledOut[i] next cycle = debugEnable ? debugLed[i] : (pattern[i] && pwmOn[i]); latency from any input to ledOut is exactly one clock.
REQ-025 SHALL keep blink/PWM counters free-running regardless of debugEnable or config writes, so channels stay phase-aligned.
REQ-026 SHALL give a config write landing on the frameStart cycle to the pending registers only; it becomes active at the next frameStart.

Reset
REQ-027 SHALL, while resetN is low, asynchronously force ledOut=0, frameStart=0, cfgReady=0, all counters=0, blinkPhase=0, heartStep=0.
REQ-028 SHALL reset pending and active mode to off and brightness to all-ones.
REQ-029 SHALL, on reset assertion mid-frame or mid-write, discard all pending writes; no partial state survives.

Verification (LedCount=3, PwmBits=4, PwmDiv=1, BlinkCycles=16)
REQ-030 SHALL cover reset: release resetN -> ledOut=000, cfgReady=1 from second clock, first frameStart 16 clocks after release.
REQ-031 SHALL cover PWM duty: ch0 mode=on bright=4 -> from next frame ledOut[0] high exactly 4 of every 16 clocks; bright=15 -> high 16/16; bright=0 -> 0/16.
REQ-032 SHALL cover frame-aligned update: write ch1 mode=on mid-frame -> ledOut[1] stays 0 until one clock after the next frameStart; two writes in one frame -> only the second takes effect.
REQ-033 SHALL cover blink/heartbeat: ch0 blink, ch2 heartbeat, bright=15 -> ch0 toggles every 16 clocks; ch2 high during steps 0 and 2 only (16 on, 16 off, 16 on, 80 off, repeat).
REQ-034 SHALL cover override and bad index: debugEnable=1 debugLed=101 -> ledOut=101 one clock later; write cfgIndex=3 -> accepted, no channel changes.
REQ-035 SHALL cover reset mid-operation: assert resetN low during active blink -> ledOut=000 immediately (asynchronous); after release all channels off.

Source files
------------

// File: rtl/oc_led_ctrl.sv
// Multi-channel LED controller: per-channel PWM brightness with off/on/blink/heartbeat
// patterns, frame-aligned configuration updates and a debug override of all outputs.
module oc_led_ctrl #(
  parameter int LedCount    = 3,
  parameter int PwmBits     = 8,
  parameter int PwmDiv      = 16,
  parameter int BlinkCycles = 39062500
) (
  input  logic                                               clock,
  input  logic                                               resetN,
  input  logic                                               cfgValid,
  output logic                                               cfgReady,
  input  logic [((LedCount > 1) ? $clog2(LedCount) : 1)-1:0] cfgIndex,
  input  logic [1:0]                                         cfgMode,
  input  logic [PwmBits-1:0]                                 cfgBright,
  input  logic                                               debugEnable,
  input  logic [LedCount-1:0]                                debugLed,
  output logic [LedCount-1:0]                                ledOut,
  output logic                                               frameStart
);
  localparam int IdxW   = (LedCount > 1) ? $clog2(LedCount) : 1;
  localparam int PrescW = (PwmDiv > 1) ? $clog2(PwmDiv) : 1;
  localparam int BlinkW = $clog2(BlinkCycles);

  localparam logic [1:0] ModeOff   = 2'd0;
  localparam logic [1:0] ModeOn    = 2'd1;
  localparam logic [1:0] ModeBlink = 2'd2;

  function automatic logic pattern_bit(input logic [1:0] mode, input logic phase,
                                       input logic [2:0] step);
    logic bit_v;
    case (mode)
      ModeOff:   bit_v = 1'b0;
      ModeOn:    bit_v = 1'b1;
      ModeBlink: bit_v = phase;
      default:   bit_v = (step == 3'd0) || (step == 3'd2);
    endcase
    return bit_v;
  endfunction

  logic [PrescW-1:0]                presc_q, presc_d;
  logic [PwmBits-1:0]               pwm_q, pwm_d;
  logic [BlinkW-1:0]                blink_q, blink_d;
  logic                             phase_q, phase_d;
  logic [2:0]                       heart_q, heart_d;
  logic                             frame_q, frame_d;
  logic                             ready_q;
  logic [LedCount-1:0][1:0]         pendMode_q, pendMode_d;
  logic [LedCount-1:0][1:0]         actMode_q, actMode_d;
  logic [LedCount-1:0][PwmBits-1:0] pendBright_q, pendBright_d;
  logic [LedCount-1:0][PwmBits-1:0] actBright_q, actBright_d;
  logic [LedCount-1:0]              led_q, led_d;
  logic [LedCount-1:0]              pwmOn;
  logic                             presc_wrap, blink_wrap, accept;

  // Free-running timebase: never gated by config traffic or debug override.
  always_comb begin
    presc_wrap = (presc_q == PrescW'(PwmDiv - 1));
    presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
    pwm_d      = presc_wrap ? pwm_q + 1'b1 : pwm_q;
    frame_d    = presc_wrap && (&pwm_q);
    blink_wrap = (blink_q == BlinkW'(BlinkCycles - 1));
    blink_d    = blink_wrap ? '0 : blink_q + 1'b1;
    phase_d    = phase_q ^ blink_wrap;
    heart_d    = blink_wrap ? heart_q + 3'd1 : heart_q;
  end

  // Active settings load on the same edge the frame pulse is raised, so the whole
  // frame (pwmCount 0 upward) sees one setting; a write on that edge stays pending.
  always_comb begin
    accept       = cfgValid && ready_q;
    pendMode_d   = pendMode_q;
    pendBright_d = pendBright_q;
    for (int i = 0; i < LedCount; i++) begin
      if (accept && (cfgIndex == IdxW'(i))) begin
        pendMode_d[i]   = cfgMode;
        pendBright_d[i] = cfgBright;
      end
    end
    actMode_d   = frame_d ? pendMode_q : actMode_q;
    actBright_d = frame_d ? pendBright_q : actBright_q;
  end

  always_comb begin
    pwmOn = '0;
    led_d = '0;
    for (int i = 0; i < LedCount; i++) begin
      pwmOn[i] = (pwm_q < actBright_q[i]) || (&actBright_q[i]);
      led_d[i] = debugEnable ? debugLed[i]
                             : (pattern_bit(actMode_q[i], phase_q, heart_q) && pwmOn[i]);
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      presc_q      <= '0;
      pwm_q        <= '0;
      blink_q      <= '0;
      phase_q      <= 1'b0;
      heart_q      <= 3'd0;
      frame_q      <= 1'b0;
      ready_q      <= 1'b0;
      pendMode_q   <= '0;
      actMode_q    <= '0;
      pendBright_q <= '1;
      actBright_q  <= '1;
      led_q        <= '0;
    end else begin
      presc_q      <= presc_d;
      pwm_q        <= pwm_d;
      blink_q      <= blink_d;
      phase_q      <= phase_d;
      heart_q      <= heart_d;
      frame_q      <= frame_d;
      ready_q      <= 1'b1;
      pendMode_q   <= pendMode_d;
      actMode_q    <= actMode_d;
      pendBright_q <= pendBright_d;
      actBright_q  <= actBright_d;
      led_q        <= led_d;
    end
  end

  assign cfgReady   = ready_q;
  assign frameStart = frame_q;
  assign ledOut     = led_q;

endmodule

// File: tb/tb_oc_led_ctrl.sv
// Bench for oc_led_ctrl: cycle-number based reference model feeding a scoreboard,
// directed scenarios plus a randomized phase.
module tb_oc_led_ctrl;
  localparam int LedCount    = 3;
  localparam int PwmBits     = 4;
  localparam int PwmDiv      = 1;
  localparam int BlinkCycles = 16;
  localparam int Levels      = 1 << PwmBits;
  localparam int FramePer    = PwmDiv * Levels;
  localparam int Full        = Levels - 1;

  logic         clock = 1'b0;
  logic         resetN = 1'b0;
  logic         cfgValid = 1'b0;
  logic         cfgReady;
  logic [1:0]   cfgIndex = 2'd0;
  logic [1:0]   cfgMode = 2'd0;
  logic [3:0]   cfgBright = 4'd0;
  logic         debugEnable = 1'b0;
  logic [2:0]   debugLed = 3'd0;
  logic [2:0]   ledOut;
  logic         frameStart;

  always #5 clock = ~clock;

  oc_led_ctrl #(
    .LedCount(LedCount), .PwmBits(PwmBits), .PwmDiv(PwmDiv), .BlinkCycles(BlinkCycles)
  ) dut (
    .clock(clock), .resetN(resetN), .cfgValid(cfgValid), .cfgReady(cfgReady),
    .cfgIndex(cfgIndex), .cfgMode(cfgMode), .cfgBright(cfgBright),
    .debugEnable(debugEnable), .debugLed(debugLed), .ledOut(ledOut),
    .frameStart(frameStart)
  );

  typedef struct packed {
    logic [2:0] led;
    logic       fs;
    logic       rdy;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  int   n;
  int   pendMode[LedCount], pendBright[LedCount];
  int   actMode[LedCount], actBright[LedCount];
  exp_t eModel, eMon;

  // Behaviour of one channel during absolute cycle k after reset release.
  function automatic logic model_on(input int mode, input int bright, input int k);
    int  pwm, half;
    logic patt;
    pwm  = (k / PwmDiv) % Levels;
    half = k / BlinkCycles;
    case (mode)
      0:       patt = 1'b0;
      1:       patt = 1'b1;
      2:       patt = (half % 2) == 1;
      default: patt = ((half % 8) == 0) || ((half % 8) == 2);
    endcase
    return patt && ((pwm < bright) || (bright == Full));
  endfunction

  // Reference model: n counts clock edges since reset release.
  initial forever begin
    @(posedge clock);
    if (!resetN) begin
      n = 0;
      for (int i = 0; i < LedCount; i++) begin
        pendMode[i] = 0; actMode[i] = 0; pendBright[i] = Full; actBright[i] = Full;
      end
    end else begin
      n = n + 1;
      eModel.rdy = 1'b1;
      eModel.fs  = (n % FramePer) == 0;
      for (int i = 0; i < LedCount; i++)
        eModel.led[i] = debugEnable ? debugLed[i] : model_on(actMode[i], actBright[i], n - 1);
      sb.push_back(eModel);
      if ((n % FramePer) == 0)
        for (int i = 0; i < LedCount; i++) begin
          actMode[i] = pendMode[i]; actBright[i] = pendBright[i];
        end
      if (cfgValid && n >= 2 && int'(cfgIndex) < LedCount) begin
        pendMode[cfgIndex]   = int'(cfgMode);
        pendBright[cfgIndex] = int'(cfgBright);
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (resetN && sb.size() > 0) begin
      eMon = sb.pop_front();
      compared++;
      if ({ledOut, frameStart, cfgReady} !== eMon) begin
        mismatched++;
        $display("FAIL scoreboard at %0t: got led=%b fs=%b rdy=%b, expected led=%b fs=%b rdy=%b",
                 $time, ledOut, frameStart, cfgReady, eMon.led, eMon.fs, eMon.rdy);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write(input int idx, input int mode, input int bright);
    cfgIndex  = 2'(idx);
    cfgMode   = 2'(mode);
    cfgBright = 4'(bright);
    cfgValid  = 1'b1;
    tick();
    cfgValid  = 1'b0;
  endtask

  task automatic wait_frame(input int ch, output int highs);
    int found;
    highs = 0;
    found = 0;
    for (int c = 0; c < 4 * FramePer && found == 0; c++) begin
      tick();
      if (frameStart) found = 1;
      else highs += int'(ledOut[ch]);
    end
    check("frame_wait", found, 1);
  endtask

  task automatic measure(input int ch, input int cycles, output int highs);
    highs = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      highs += int'(ledOut[ch]);
    end
  endtask

  initial begin
    int h, first, found, anyOn;

    repeat (3) @(posedge clock);
    #1;
    check("reset_led", int'(ledOut), 0);
    check("reset_frame", int'(frameStart), 0);
    check("reset_ready", int'(cfgReady), 0);
    @(negedge clock);
    resetN = 1'b1;
    #1;
    check("ready_before_edge", int'(cfgReady), 0);

    first = 0;
    for (int c = 1; c <= 40 && first == 0; c++) begin
      tick();
      if (frameStart) first = c;
    end
    check("first_frame_edge", first, 16);

    // PWM duty at three brightness levels; each write lands on a frameStart cycle.
    write(0, 1, 4);
    wait_frame(0, h);
    check("duty_before_activate", h, 0);
    measure(0, 16, h);
    check("duty_4", h, 4);
    write(0, 1, 15);
    wait_frame(0, h);
    measure(0, 16, h);
    check("duty_15", h, 16);
    write(0, 1, 0);
    wait_frame(0, h);
    measure(0, 16, h);
    check("duty_0", h, 0);

    // Frame-aligned update and last-write-wins.
    write(1, 1, 15);
    wait_frame(1, h);
    check("align_hold", h, 0);
    check("align_at_frame", int'(ledOut[1]), 0);
    tick();
    check("align_after_frame", int'(ledOut[1]), 1);
    write(2, 1, 15);
    write(2, 0, 15);
    wait_frame(2, h);
    measure(2, 16, h);
    check("last_write_wins", h, 0);

    // Blink and heartbeat.
    write(0, 2, 15);
    write(1, 0, 15);
    write(2, 3, 15);
    wait_frame(0, h);
    measure(0, 128, h);
    check("blink_duty", h, 64);
    measure(2, 128, h);
    check("heartbeat_duty", h, 32);

    // Debug override and out-of-range index.
    debugEnable = 1'b1;
    debugLed    = 3'b101;
    tick();
    check("debug_led", int'(ledOut), 5);
    debugLed = 3'b010;
    tick();
    check("debug_led_2", int'(ledOut), 2);
    debugEnable = 1'b0;
    check("ready_bad_index", int'(cfgReady), 1);
    write(3, 1, 0);
    repeat (40) tick();

    // Asynchronous reset during blink.
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      tick();
      if (ledOut[0]) found = 1;
    end
    check("blink_on_before_reset", found, 1);
    #2;
    resetN = 1'b0;
    sb.delete();
    #1;
    check("async_reset_led", int'(ledOut), 0);
    check("async_reset_ready", int'(cfgReady), 0);
    @(posedge clock);
    @(negedge clock);
    resetN = 1'b1;
    anyOn = 0;
    for (int c = 0; c < 48; c++) begin
      tick();
      if (ledOut != 3'b000) anyOn++;
    end
    check("after_reset_all_off", anyOn, 0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      cfgValid    = ($urandom_range(0, 2) == 0);
      cfgIndex    = 2'($urandom_range(0, 3));
      cfgMode     = 2'($urandom_range(0, 3));
      cfgBright   = 4'($urandom_range(0, 15));
      debugEnable = ($urandom_range(0, 7) == 0);
      debugLed    = 3'($urandom_range(0, 7));
      tick();
    end
    cfgValid    = 1'b0;
    debugEnable = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
